clock_set_ctrl: RTL and testbench

//  Time-setting controller for the digital clock. Consumes two debounced, active-low button levels (MODE, INC).

---
 rtl/clock_ui_pkg.sv | 26 ++
 rtl/clock_set_ctrl_if.sv | 22 ++
 rtl/btn_press_rpt.sv | 67 ++++++
 rtl/clock_set_ctrl.sv | 106 ++++++++++
 tb/tb_clock_set_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/clock_ui_pkg.sv
// Shared clock-UI definitions: set-mode encodings, default millisecond timings
// and the MODE-button field sequence.
package clock_ui_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOUR = 2'd1,
    ST_MIN  = 2'd2,
    ST_SEC  = 2'd3
  } set_state_e;

  localparam int TIMEOUT_MS    = 10000;
  localparam int BLINK_HALF_MS = 250;
  localparam int LONG_MS       = 800;
  localparam int REPEAT_MS     = 200;

  function automatic set_state_e next_field(input set_state_e s);
    case (s)
      ST_RUN:  return ST_HOUR;
      ST_HOUR: return ST_MIN;
      ST_MIN:  return ST_SEC;
      default: return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button-in / control-out bundle between the debouncers, the set controller
// and the hh:mm:ss counter chain. master = controller side.
interface clock_set_ctrl_if;
  logic       btn_mode_n;
  logic       btn_inc_n;
  logic [1:0] set_mode;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic       sec_hold;
  logic       blink_on;

  modport master (
    input  btn_mode_n, btn_inc_n,
    output set_mode, inc_hour, inc_min, clr_sec, sec_hold, blink_on
  );

  modport slave (
    output btn_mode_n, btn_inc_n,
    input  set_mode, inc_hour, inc_min, clr_sec, sec_hold, blink_on
  );
endinterface

// File: rtl/btn_press_rpt.sv
// Per-button press detector with optional hold-to-repeat timer.
// A button held through reset is ignored until it has been seen released.
module btn_press_rpt #(
  parameter bit RPT_EN    = 1'b0,
  parameter int LONG_MS   = 800,
  parameter int REPEAT_MS = 200
) (
  input  logic clk_1k,
  input  logic rst_n,
  input  logic btn_n,
  input  logic rpt_cancel,
  output logic press_o,
  output logic rpt_o
);

  logic prev, armed, press_now;

  assign press_now = armed & prev & ~btn_n;

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= 1'b1;
      armed   <= 1'b0;
      press_o <= 1'b0;
    end else begin
      prev    <= btn_n;
      press_o <= press_now;
      if (btn_n) armed <= 1'b1;
    end
  end

  if (RPT_EN) begin : g_rpt
    logic        rpt_act, rpt_first;
    logic [15:0] rpt_cnt;

    // first repeat after LONG_MS, then every REPEAT_MS; cancel blocks until release
    always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
        rpt_act   <= 1'b0;
        rpt_first <= 1'b0;
        rpt_cnt   <= '0;
        rpt_o     <= 1'b0;
      end else if (press_now) begin
        rpt_act   <= 1'b1;
        rpt_first <= 1'b1;
        rpt_cnt   <= '0;
        rpt_o     <= 1'b0;
      end else if (btn_n || rpt_cancel || !rpt_act) begin
        rpt_act   <= 1'b0;
        rpt_cnt   <= '0;
        rpt_o     <= 1'b0;
      end else if (rpt_cnt == (rpt_first ? 16'(LONG_MS - 1) : 16'(REPEAT_MS - 1))) begin
        rpt_first <= 1'b0;
        rpt_cnt   <= '0;
        rpt_o     <= 1'b1;
      end else begin
        rpt_cnt   <= rpt_cnt + 16'd1;
        rpt_o     <= 1'b0;
      end
    end
  end else begin : g_norpt
    logic unused_cancel;
    assign unused_cancel = rpt_cancel;
    assign rpt_o         = 1'b0;
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: MODE steps RUN->HOUR->MIN->SEC, INC strobes the
// selected field. Define CLOCK_SET_AUTOREPEAT_EN for INC hold auto-repeat.
module clock_set_ctrl #(
  parameter int TIMEOUT_MS    = clock_ui_pkg::TIMEOUT_MS,
  parameter int BLINK_HALF_MS = clock_ui_pkg::BLINK_HALF_MS,
  parameter int LONG_MS       = clock_ui_pkg::LONG_MS,
  parameter int REPEAT_MS     = clock_ui_pkg::REPEAT_MS
) (
  input  logic              clk_1k,
  input  logic              rst_n,
  clock_set_ctrl_if.master  bus
);
  import clock_ui_pkg::*;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam bit INC_RPT = 1'b1;
`else
  localparam bit INC_RPT = 1'b0;
`endif

  set_state_e  state, state_n;
  logic [13:0] idle, idle_n;
  logic [15:0] blink_cnt, blink_cnt_n;
  logic        blink, blink_n;
  logic        inc_hour_q, inc_min_q, clr_sec_q;
  logic        inc_hour_n, inc_min_n, clr_sec_n;
  logic        mode_p, mode_r, inc_p, inc_r;
  logic        in_set, timeout, inc_ev, strobe_n, st_chg;

  btn_press_rpt #(.RPT_EN(1'b0), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_mode (
    .clk_1k(clk_1k), .rst_n(rst_n), .btn_n(bus.btn_mode_n),
    .rpt_cancel(1'b0), .press_o(mode_p), .rpt_o(mode_r)
  );

  btn_press_rpt #(.RPT_EN(INC_RPT), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_inc (
    .clk_1k(clk_1k), .rst_n(rst_n), .btn_n(bus.btn_inc_n),
    .rpt_cancel(st_chg), .press_o(inc_p), .rpt_o(inc_r)
  );

  always_comb begin
    state_n    = state;
    inc_hour_n = 1'b0;
    inc_min_n  = 1'b0;
    clr_sec_n  = 1'b0;
    in_set     = (state != ST_RUN);
    timeout    = in_set && (idle == 14'(TIMEOUT_MS - 1));
    inc_ev     = inc_p | (inc_r & (state == ST_HOUR || state == ST_MIN));

    // timeout beats MODE, MODE beats INC (the INC press is simply dropped)
    if (timeout)                state_n = ST_RUN;
    else if (mode_p || mode_r)  state_n = next_field(state);
    else if (inc_ev) begin
      case (state)
        ST_HOUR: inc_hour_n = 1'b1;
        ST_MIN:  inc_min_n  = 1'b1;
        ST_SEC:  clr_sec_n  = 1'b1;
        default: ;
      endcase
    end

    strobe_n = inc_hour_n | inc_min_n | clr_sec_n;
    st_chg   = (state_n != state);

    if (state_n == ST_RUN || st_chg || mode_p || inc_p || strobe_n) idle_n = '0;
    else                                                              idle_n = idle + 14'd1;

    if (state_n == ST_RUN || st_chg || strobe_n) begin
      blink_cnt_n = '0;
      blink_n     = 1'b1;
    end else if (blink_cnt == 16'(BLINK_HALF_MS - 1)) begin
      blink_cnt_n = '0;
      blink_n     = ~blink;
    end else begin
      blink_cnt_n = blink_cnt + 16'd1;
      blink_n     = blink;
    end
  end

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      idle       <= '0;
      blink_cnt  <= '0;
      blink      <= 1'b1;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_sec_q  <= 1'b0;
    end else begin
      state      <= state_n;
      idle       <= idle_n;
      blink_cnt  <= blink_cnt_n;
      blink      <= blink_n;
      inc_hour_q <= inc_hour_n;
      inc_min_q  <= inc_min_n;
      clr_sec_q  <= clr_sec_n;
    end
  end

  assign bus.set_mode = state;
  assign bus.inc_hour = inc_hour_q;
  assign bus.inc_min  = inc_min_q;
  assign bus.clr_sec  = clr_sec_q;
  assign bus.sec_hold = (state == ST_SEC);
  assign bus.blink_on = blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: the driver queues expected mode changes
// and strobes (cycle-stamped); a negedge monitor pops and compares each one.
module tb_clock_set_ctrl;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [2:0] strb;   // {inc_hour, inc_min, clr_sec}
    logic       hold;
    string      name;
  } ev_t;

  logic clk_1k = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];

  clock_set_ctrl_if bus();

  clock_set_ctrl dut (.clk_1k(clk_1k), .rst_n(rst_n), .bus(bus));

  always #5 clk_1k = ~clk_1k;
  always @(posedge clk_1k) cyc <= cyc + 1;

  function automatic void expect_ev(input int c, input logic [1:0] m,
                                    input logic [2:0] s, input string nm);
    ev_t e;
    e.cyc = c; e.mode = m; e.strb = s; e.hold = (m == 2'd3); e.name = nm;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // monitor: any strobe or set_mode change is an event that must be queued
  initial begin
    logic [1:0] last_mode;
    logic [2:0] strb;
    ev_t        e;
    last_mode = 2'd0;
    forever begin
      @(negedge clk_1k);
      strb = {bus.inc_hour, bus.inc_min, bus.clr_sec};
      if (strb != 3'b000 || bus.set_mode != last_mode) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d mode=%0d strb=%b, expected no event",
                   cyc, bus.set_mode, strb);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.mode != bus.set_mode || e.strb != strb || e.hold != bus.sec_hold) begin
            errors++;
            $display("FAIL %s: got cyc=%0d mode=%0d strb=%b hold=%b, expected cyc=%0d mode=%0d strb=%b hold=%b",
                     e.name, cyc, bus.set_mode, strb, bus.sec_hold, e.cyc, e.mode, e.strb, e.hold);
          end
        end
      end
      last_mode = bus.set_mode;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic tap_mode(input int lo, input int hi, input logic [1:0] m, input string nm);
    expect_ev(cyc + 2, m, 3'b000, nm);
    bus.btn_mode_n = 1'b0;
    repeat (lo) @(negedge clk_1k);
    bus.btn_mode_n = 1'b1;
    repeat (hi) @(negedge clk_1k);
  endtask

  initial begin
    int c, e0;
    int ks[10];
    bus.btn_mode_n = 1'b1;
    bus.btn_inc_n  = 1'b1;
    ks = '{0, 249, 250, 499, 500, 5000, 9749, 9750, 9999, 10000};

    // 1: reset values, then 100 quiet cycles
    repeat (2) @(negedge clk_1k);
    chk("rst_set_mode", int'(bus.set_mode), 0);
    chk("rst_blink_on", int'(bus.blink_on), 1);
    chk("rst_strobes",  int'({bus.inc_hour, bus.inc_min, bus.clr_sec}), 0);
    chk("rst_sec_hold", int'(bus.sec_hold), 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk_1k);
    chk("idle_blink_on", int'(bus.blink_on), 1);

    // 2: MODE cycles through all four states
    tap_mode(100, 100, 2'd1, "mode_to_hour");
    tap_mode(100, 100, 2'd2, "mode_to_min");
    tap_mode(100, 100, 2'd3, "mode_to_sec");
    tap_mode(100, 100, 2'd0, "mode_to_run");

    // 3: INC in SET_HOUR, short press then long hold
    tap_mode(100, 100, 2'd1, "t3_hour");
    expect_ev(cyc + 2, 2'd1, 3'b100, "inc_hour_short");
    bus.btn_inc_n = 1'b0;
    repeat (50) @(negedge clk_1k);
    bus.btn_inc_n = 1'b1;
    repeat (50) @(negedge clk_1k);
    c = cyc;
    expect_ev(c + 2, 2'd1, 3'b100, "inc_hour_long_first");
`ifdef CLOCK_SET_AUTOREPEAT_EN
    for (int k = 0; k < 6; k++) expect_ev(c + 802 + 200 * k, 2'd1, 3'b100, "inc_hour_repeat");
`endif
    bus.btn_inc_n = 1'b0;
    repeat (2000) @(negedge clk_1k);
    bus.btn_inc_n = 1'b1;
    repeat (50) @(negedge clk_1k);
    tap_mode(100, 100, 2'd2, "t3_min");

    // 4: MODE and INC together in SET_MIN: MODE wins, no strobe
    expect_ev(cyc + 2, 2'd3, 3'b000, "both_mode_wins");
    bus.btn_mode_n = 1'b0;
    bus.btn_inc_n  = 1'b0;
    repeat (50) @(negedge clk_1k);
    bus.btn_mode_n = 1'b1;
    bus.btn_inc_n  = 1'b1;
    repeat (50) @(negedge clk_1k);
    tap_mode(100, 100, 2'd0, "t4_run");

    // 5: idle timeout from SET_MIN with blink checks
    tap_mode(100, 100, 2'd1, "t5_hour");
    e0 = cyc + 2;
    expect_ev(e0, 2'd2, 3'b000, "t5_min_entry");
    expect_ev(e0 + 10000, 2'd0, 3'b000, "timeout_to_run");
    bus.btn_mode_n = 1'b0;
    @(negedge clk_1k);
    bus.btn_mode_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      while (cyc < e0 + ks[i]) @(negedge clk_1k);
      chk($sformatf("blink_at_%0d", ks[i]), int'(bus.blink_on),
          (ks[i] >= 10000) ? 1 : (((ks[i] / 250) % 2 == 0) ? 1 : 0));
    end
    repeat (20) @(negedge clk_1k);

    // 6: reset in SET_SEC with both buttons held through reset release
    tap_mode(100, 100, 2'd1, "t6_hour");
    tap_mode(100, 100, 2'd2, "t6_min");
    tap_mode(100, 100, 2'd3, "t6_sec");
    expect_ev(cyc + 1, 2'd0, 3'b000, "reset_to_run");
    #1;
    rst_n          = 1'b0;
    bus.btn_inc_n  = 1'b0;
    bus.btn_mode_n = 1'b0;
    repeat (5) @(negedge clk_1k);
    chk("midrst_set_mode", int'(bus.set_mode), 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk_1k);
    chk("held_thru_reset_mode", int'(bus.set_mode), 0);
    bus.btn_mode_n = 1'b1;
    repeat (20) @(negedge clk_1k);
    tap_mode(50, 50, 2'd1, "t6b_hour");
    tap_mode(50, 50, 2'd2, "t6b_min");
    tap_mode(50, 50, 2'd3, "t6b_sec");
    bus.btn_inc_n = 1'b1;
    repeat (20) @(negedge clk_1k);
    expect_ev(cyc + 2, 2'd3, 3'b001, "clr_sec_after_repress");
    bus.btn_inc_n = 1'b0;
    repeat (30) @(negedge clk_1k);
    bus.btn_inc_n = 1'b1;
    repeat (30) @(negedge clk_1k);
    tap_mode(50, 50, 2'd0, "t6_run");
    repeat (20) @(negedge clk_1k);

    chk("events_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
